reaction_timer_ctrl: RTL

//  Parametrised reaction-timer controller: LED fill-up countdown, LFSR-random hold,

---
 rtl/rtimer_pkg.sv | 42 ++++
 rtl/lfsr_n.sv | 30 +++
 rtl/reaction_timer_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rtimer_pkg.sv
// Shared types and constants for the reaction-timer controller.
package rtimer_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LIGHTS  = 3'd1,
    ST_DELAY   = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FALSE   = 3'd5
  } state_t;

  // Maximal-length Fibonacci tap masks (bit k = stage k+1) for widths 8..16
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // Alternating LED pattern 1010.. with bit0 clear, limited to n LEDs
  function automatic logic [15:0] alt_pattern(input int unsigned n);
    logic [15:0] pat;
    pat = 16'h0000;
    for (int unsigned i = 0; i < 16; i++) begin
      if ((i < n) && (i % 2 == 1)) pat[i] = 1'b1;
    end
    return pat;
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// Fibonacci LFSR, shifts left on each enable; seeded with 1 so it never sits at zero.
module lfsr_n
  import rtimer_pkg::*;
#(
  parameter int unsigned          WIDTH = 14,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(lfsr_taps(WIDTH)),
  parameter int unsigned          OUT_W = WIDTH
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic             w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign q    = r_q[OUT_W-1:0];

  // Shift register advancing once per enable
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= WIDTH'(1);
    end else if (en) begin
      r_q <= {r_q[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer controller: LED fill-up, random hold, lights-out, ms reaction measurement
// with false-start detection, timeout and best-time tracking.
module reaction_timer_ctrl
  import rtimer_pkg::*;
#(
  parameter int unsigned N_LEDS       = 10,
  parameter int unsigned STEP_MS      = 500,
  parameter int unsigned LFSR_W       = 14,
  parameter int unsigned DELAY_MIN_MS = 250,
  parameter int unsigned DELAY_BITS   = 12,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_MS       = 9999
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              tick_ms,
  input  logic              start,
  input  logic              react,
  input  logic              clear_best,
  output logic [N_LEDS-1:0] ledr,
  output logic [CNT_W-1:0]  react_time,
  output logic [CNT_W-1:0]  best_time,
  output logic              result_valid,
  output logic              false_start,
  output logic              timeout,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_MS - 1);
  localparam logic [CNT_W-1:0]  MEAS_LAST = CNT_W'(MAX_MS - 1);
  localparam logic [CNT_W-1:0]  MAX_VAL   = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0]  DLY_MIN   = CNT_W'(DELAY_MIN_MS);
  localparam logic [N_LEDS-1:0] LED_ALT   = N_LEDS'(alt_pattern(N_LEDS));

  // Reject parameter sets that would overflow the counters or break the LFSR
  if ((N_LEDS < 2) || (N_LEDS > 16) || (LFSR_W < 8) || (LFSR_W > 16) ||
      (DELAY_BITS < 1) || (DELAY_BITS > LFSR_W) || (STEP_MS < 1) || (MAX_MS < 1) ||
      (CNT_W < 1) || (CNT_W > 32) ||
      (64'(MAX_MS) >= (64'd1 << CNT_W)) || (64'(STEP_MS) >= (64'd1 << CNT_W)) ||
      ((64'(DELAY_MIN_MS) + (64'd1 << DELAY_BITS) - 64'd1) >= (64'd1 << CNT_W))) begin : g_bad_params
    $error("reaction_timer_ctrl: illegal parameter combination");
  end

  state_t              r_state;
  logic [N_LEDS-1:0]   r_ledr;
  logic [CNT_W-1:0]    r_step;
  logic [CNT_W-1:0]    r_delay;
  logic [CNT_W-1:0]    r_meas;
  logic [CNT_W-1:0]    r_react_time;
  logic [CNT_W-1:0]    r_best;
  logic                r_result_valid;
  logic                r_false_start;
  logic                r_timeout;
  logic                r_busy;
  logic [DELAY_BITS-1:0] w_rand;
  logic [CNT_W-1:0]    w_delay_load;

  lfsr_n #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(lfsr_taps(LFSR_W))),
    .OUT_W (DELAY_BITS)
  ) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .en       (tick_ms),
    .q        (w_rand)
  );

  assign w_delay_load = DLY_MIN + CNT_W'(w_rand);

  assign ledr         = r_ledr;
  assign react_time   = r_react_time;
  assign best_time    = r_best;
  assign result_valid = r_result_valid;
  assign false_start  = r_false_start;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

  // Controller FSM with counters and registered outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= ST_IDLE;
      r_ledr         <= '0;
      r_step         <= '0;
      r_delay        <= '0;
      r_meas         <= '0;
      r_react_time   <= '0;
      r_best         <= '1;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
      r_timeout      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_FALSE: begin
          // start wins over a coincident react here
          if (start) begin
            r_state       <= ST_LIGHTS;
            r_step        <= '0;
            r_ledr        <= '0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_LIGHTS: begin
          if (react) begin
            r_state       <= ST_FALSE;
            r_ledr        <= LED_ALT;
            r_false_start <= 1'b1;
            r_busy        <= 1'b0;
          end else if (tick_ms) begin
            if (r_step == STEP_LAST) begin
              r_step <= '0;
              r_ledr <= {r_ledr[N_LEDS-2:0], 1'b1};
              if (&r_ledr[N_LEDS-2:0]) begin
                r_state <= ST_DELAY;
                r_delay <= w_delay_load;
              end
            end else begin
              r_step <= r_step + CNT_W'(1);
            end
          end
        end
        ST_DELAY: begin
          // react on the expiry cycle still counts as a false start
          if (react) begin
            r_state       <= ST_FALSE;
            r_ledr        <= LED_ALT;
            r_false_start <= 1'b1;
            r_busy        <= 1'b0;
          end else if (tick_ms) begin
            if (r_delay <= CNT_W'(1)) begin
              r_state <= ST_MEASURE;
              r_ledr  <= '0;
              r_meas  <= '0;
            end else begin
              r_delay <= r_delay - CNT_W'(1);
            end
          end
        end
        ST_MEASURE: begin
          if (react) begin
            r_state        <= ST_DONE;
            r_react_time   <= r_meas;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            if (r_meas < r_best) r_best <= r_meas;
          end else if (tick_ms) begin
            if (r_meas == MEAS_LAST) begin
              r_state        <= ST_DONE;
              r_react_time   <= MAX_VAL;
              r_result_valid <= 1'b1;
              r_timeout      <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_meas <= r_meas + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ledr  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
      // Clearing the best time overrides a same-cycle update
      if (clear_best) r_best <= '1;
    end
  end

endmodule
